// File: rtl/dram_queue_block_writer_if.sv
// Input-word, DRAM block-write and occupancy signals of one output-queue block writer.
interface dram_queue_block_writer_if #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned DRAM_DATA_WIDTH = 2 * (DATA_WIDTH + CTRL_WIDTH),
    parameter int unsigned DRAM_ADDR_WIDTH = 22,
    parameter int unsigned NUM_BLOCKS      = 64
);
    localparam int unsigned UsedW = $clog2(NUM_BLOCKS) + 1;

    logic [DATA_WIDTH-1:0]      in_data;
    logic [CTRL_WIDTH-1:0]      in_ctrl;
    logic                       in_wr;
    logic                       in_rdy;
    logic                       dram_wr_req;
    logic [DRAM_ADDR_WIDTH-1:0] dram_wr_ptr;
    logic                       dram_wr_data_vld;
    logic [DRAM_DATA_WIDTH-1:0] dram_wr_data;
    logic                       dram_wr_ack;
    logic                       dram_wr_full;
    logic                       dram_wr_done;
    logic                       rd_blk_done;
    logic                       blk_stored;
    logic [UsedW-1:0]           blocks_used;
    logic                       dram_q_full;

    modport master (
        input  in_data, in_ctrl, in_wr, dram_wr_ack, dram_wr_full, dram_wr_done, rd_blk_done,
        output in_rdy, dram_wr_req, dram_wr_ptr, dram_wr_data_vld, dram_wr_data, blk_stored,
               blocks_used, dram_q_full
    );

    modport slave (
        output in_data, in_ctrl, in_wr, dram_wr_ack, dram_wr_full, dram_wr_done, rd_blk_done,
        input  in_rdy, dram_wr_req, dram_wr_ptr, dram_wr_data_vld, dram_wr_data, blk_stored,
               blocks_used, dram_q_full
    );
endinterface

// File: rtl/dram_queue_block_writer.sv
// Packs queue words pairwise into ping-pong block buffers and writes full blocks to DRAM.
// Defining DRAM_WR_FLUSH_EN adds an idle-timeout flush of partial blocks.
module dram_queue_block_writer #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned DRAM_DATA_WIDTH = 2 * (DATA_WIDTH + CTRL_WIDTH),
    parameter int unsigned DRAM_ADDR_WIDTH = 22,
    parameter int unsigned BLOCK_WORDS     = 16,
    parameter int unsigned NUM_BLOCKS      = 64,
    parameter int unsigned DRAM_BASE_ADDR  = 0,
    parameter int unsigned FLUSH_TIMEOUT   = 32
) (
    input logic clk,
    input logic reset,
    dram_queue_block_writer_if.master bus
);
    localparam int unsigned HalfW = DATA_WIDTH + CTRL_WIDTH;
    localparam int unsigned IdxW  = $clog2(BLOCK_WORDS);
    localparam int unsigned LenW  = IdxW + 1;
    localparam int unsigned BlkW  = $clog2(NUM_BLOCKS);
    localparam int unsigned UsedW = BlkW + 1;

    localparam logic [IdxW-1:0]            LastIdx  = IdxW'(BLOCK_WORDS - 1);
    localparam logic [LenW-1:0]            FullLen  = LenW'(BLOCK_WORDS);
    localparam logic [UsedW-1:0]           MaxUsed  = UsedW'(NUM_BLOCKS);
    localparam logic [DRAM_ADDR_WIDTH-1:0] BaseAddr = DRAM_ADDR_WIDTH'(DRAM_BASE_ADDR);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_XFER      = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [DRAM_DATA_WIDTH-1:0] mem_q [2*BLOCK_WORDS];

    logic [1:0]            state_q, state_d;
    logic [HalfW-1:0]      half_q, half_d;
    logic                  half_vld_q, half_vld_d;
    logic                  fill_buf_q, fill_buf_d;
    logic [IdxW-1:0]       fill_idx_q, fill_idx_d;
    logic [1:0]            buf_full_q, buf_full_d;
    logic [1:0][LenW-1:0]  buf_len_q, buf_len_d;
    logic                  drain_buf_q, drain_buf_d;
    logic [IdxW-1:0]       xfer_idx_q, xfer_idx_d;
    logic [BlkW-1:0]       wr_blk_q, wr_blk_d;
    logic [UsedW-1:0]      used_q, used_d;
    logic                  blk_stored_q, blk_stored_d;

    logic                       in_rdy, accept, xfer_vld, q_full, rd_dec;
    logic                       close_buf, blk_done, flush_go;
    logic [LenW-1:0]            close_len;
    logic                       mem_we;
    logic [IdxW:0]              mem_waddr;
    logic [DRAM_DATA_WIDTH-1:0] mem_wdata;

    assign in_rdy   = !buf_full_q[fill_buf_q];
    assign accept   = bus.in_wr && in_rdy;
    assign xfer_vld = (state_q == ST_XFER) && !bus.dram_wr_full;
    assign q_full   = (used_q == MaxUsed);
    assign rd_dec   = bus.rd_blk_done && (used_q != '0);

`ifdef DRAM_WR_FLUSH_EN
    localparam int unsigned IdleW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(FLUSH_TIMEOUT - 1);

    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             partial;

    // A partial fill exists only while the fill buffer can still take words.
    assign partial  = in_rdy && (half_vld_q || (fill_idx_q != '0));
    assign flush_go = partial && !bus.in_wr && (idle_cnt_q == IdleLast);

    always_comb begin
        idle_cnt_d = idle_cnt_q + IdleW'(1);
        if (bus.in_wr || !partial || flush_go) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign flush_go = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        half_vld_d   = half_vld_q;
        fill_buf_d   = fill_buf_q;
        fill_idx_d   = fill_idx_q;
        buf_full_d   = buf_full_q;
        buf_len_d    = buf_len_q;
        drain_buf_d  = drain_buf_q;
        xfer_idx_d   = xfer_idx_q;
        wr_blk_d     = wr_blk_q;
        used_d       = used_q;
        blk_stored_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = {fill_buf_q, fill_idx_q};
        mem_wdata    = {half_q, bus.in_ctrl, bus.in_data};
        close_buf    = 1'b0;
        close_len    = FullLen;
        blk_done     = 1'b0;

        if (accept) begin
            if (!half_vld_q) begin
                half_d     = {bus.in_ctrl, bus.in_data};
                half_vld_d = 1'b1;
            end else begin
                mem_we     = 1'b1;
                half_vld_d = 1'b0;
                if (fill_idx_q == LastIdx) begin
                    close_buf = 1'b1;
                end else begin
                    fill_idx_d = fill_idx_q + IdxW'(1);
                end
            end
        end else if (flush_go) begin
            // Entries at or beyond close_len read back as zero, so only the odd half is written.
            mem_we     = half_vld_q;
            mem_wdata  = {half_q, {HalfW{1'b0}}};
            half_vld_d = 1'b0;
            close_buf  = 1'b1;
            close_len  = {1'b0, fill_idx_q} + LenW'(half_vld_q);
        end

        if (close_buf) begin
            buf_full_d[fill_buf_q] = 1'b1;
            buf_len_d[fill_buf_q]  = close_len;
            fill_buf_d             = ~fill_buf_q;
            fill_idx_d             = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (buf_full_q[drain_buf_q] && !q_full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.dram_wr_ack) begin
                    state_d    = ST_XFER;
                    xfer_idx_d = '0;
                end
            end
            ST_XFER: begin
                if (xfer_vld) begin
                    xfer_idx_d = xfer_idx_q + IdxW'(1);
                    if (xfer_idx_q == LastIdx) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (bus.dram_wr_done) begin
                    buf_full_d[drain_buf_q] = 1'b0;
                    drain_buf_d             = ~drain_buf_q;
                    wr_blk_d                = wr_blk_q + BlkW'(1);
                    blk_stored_d            = 1'b1;
                    blk_done                = 1'b1;
                    state_d                 = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (blk_done && !rd_dec) begin
            used_d = used_q + UsedW'(1);
        end else if (!blk_done && rd_dec) begin
            used_d = used_q - UsedW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            half_q       <= '0;
            half_vld_q   <= 1'b0;
            fill_buf_q   <= 1'b0;
            fill_idx_q   <= '0;
            buf_full_q   <= '0;
            buf_len_q    <= {2{FullLen}};
            drain_buf_q  <= 1'b0;
            xfer_idx_q   <= '0;
            wr_blk_q     <= '0;
            used_q       <= '0;
            blk_stored_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            half_vld_q   <= half_vld_d;
            fill_buf_q   <= fill_buf_d;
            fill_idx_q   <= fill_idx_d;
            buf_full_q   <= buf_full_d;
            buf_len_q    <= buf_len_d;
            drain_buf_q  <= drain_buf_d;
            xfer_idx_q   <= xfer_idx_d;
            wr_blk_q     <= wr_blk_d;
            used_q       <= used_d;
            blk_stored_q <= blk_stored_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.in_rdy           = in_rdy;
    assign bus.dram_wr_req      = (state_q == ST_REQ);
    assign bus.dram_wr_ptr      = BaseAddr + DRAM_ADDR_WIDTH'({wr_blk_q, {IdxW{1'b0}}});
    assign bus.dram_wr_data_vld = xfer_vld;
    assign bus.dram_wr_data     = (xfer_vld && ({1'b0, xfer_idx_q} < buf_len_q[drain_buf_q]))
                                  ? mem_q[{drain_buf_q, xfer_idx_q}] : '0;
    assign bus.blk_stored       = blk_stored_q;
    assign bus.blocks_used      = used_q;
    assign bus.dram_q_full      = q_full;

endmodule

// File: tb/tb_dram_queue_block_writer.sv
// Directed bench: an arbiter model acks, stalls and completes block writes while recording
// request pointers and data beats for comparison with hand-computed words.
module tb_dram_queue_block_writer;
    localparam int BW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dram_queue_block_writer_if bus ();

    dram_queue_block_writer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [143:0] beats[$];
    logic [21:0]  ptrs[$];
    logic [6:0]   used_log[$];
    int stored = 0;
    int gaps = 0;
    bit stall_en = 0;
    bit rd_with_done = 0;
    bit rd_once = 0;

    task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Arbiter model: samples DUT outputs at the falling edge, then drives next-cycle inputs.
    initial begin
        int xcyc = 100;
        int blk_beats = 0;
        int done_cnt = 0;
        bit in_blk = 0;
        bus.dram_wr_ack  = 1'b0;
        bus.dram_wr_full = 1'b0;
        bus.dram_wr_done = 1'b0;
        bus.rd_blk_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.dram_wr_ack  = 1'b0;
                bus.dram_wr_full = 1'b0;
                bus.dram_wr_done = 1'b0;
                bus.rd_blk_done  = 1'b0;
                xcyc = 100;
                blk_beats = 0;
                done_cnt = 0;
                in_blk = 0;
            end else begin
                if (bus.dram_wr_full) begin
                    check_eq("vld_while_full", 144'(bus.dram_wr_data_vld), 144'(0));
                end
                if (bus.dram_wr_data_vld) begin
                    beats.push_back(bus.dram_wr_data);
                    blk_beats++;
                    in_blk = 1;
                    if (blk_beats == BW) begin
                        blk_beats = 0;
                        in_blk = 0;
                        done_cnt = 2;
                    end
                end else if (in_blk) begin
                    gaps++;
                end
                if (bus.blk_stored) begin
                    stored++;
                    used_log.push_back(bus.blocks_used);
                end
                bus.dram_wr_done = 1'b0;
                bus.rd_blk_done  = 1'b0;
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        bus.dram_wr_done = 1'b1;
                        bus.rd_blk_done  = rd_with_done;
                    end
                end
                if (rd_once) begin
                    bus.rd_blk_done = 1'b1;
                    rd_once = 0;
                end
                if (bus.dram_wr_req && !bus.dram_wr_ack) begin
                    bus.dram_wr_ack = 1'b1;
                    ptrs.push_back(bus.dram_wr_ptr);
                    xcyc = 0;
                end else begin
                    bus.dram_wr_ack = 1'b0;
                    if (xcyc < 100) xcyc++;
                end
                bus.dram_wr_full = stall_en && (xcyc >= 3) && (xcyc <= 5);
            end
        end
    end

    task automatic push_word(input logic [63:0] d, input logic [7:0] c);
        int n = 0;
        while (!bus.in_rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check_eq("push_timeout", 144'(bus.in_rdy), 144'(1));
        bus.in_wr   = 1'b1;
        bus.in_data = d;
        bus.in_ctrl = c;
        @(negedge clk);
        bus.in_wr = 1'b0;
    endtask

    task automatic push_block(input logic [63:0] base, input bit ctrl_idx);
        for (int i = 0; i < 32; i++) begin
            push_word(base + 64'(i), ctrl_idx ? 8'(i + 1) : 8'h00);
        end
    endtask

    task automatic wait_stored(input int target, input string tag);
        int n = 0;
        while (stored < target && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, 144'(stored >= target), 144'(1));
        @(negedge clk);
    endtask

    task automatic clear_logs();
        beats.delete();
        ptrs.delete();
        used_log.delete();
        stored = 0;
        gaps = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_logs();
        reset = 1'b0;
    endtask

    initial begin
        bus.in_wr   = 1'b0;
        bus.in_data = '0;
        bus.in_ctrl = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_in_rdy", 144'(bus.in_rdy), 144'(1));
        check_eq("rst_req", 144'(bus.dram_wr_req), 144'(0));
        check_eq("rst_ptr", 144'(bus.dram_wr_ptr), 144'(0));
        check_eq("rst_vld", 144'(bus.dram_wr_data_vld), 144'(0));
        check_eq("rst_data", bus.dram_wr_data, 144'(0));
        check_eq("rst_stored", 144'(bus.blk_stored), 144'(0));
        check_eq("rst_used", 144'(bus.blocks_used), 144'(0));
        check_eq("rst_qfull", 144'(bus.dram_q_full), 144'(0));
        reset = 1'b0;
        @(negedge clk);

        // Basic block: data=i, ctrl=0.
        push_block(64'd0, 1'b0);
        wait_stored(1, "basic_done");
        check_eq("basic_nreq", 144'(ptrs.size()), 144'(1));
        check_eq("basic_ptr", 144'(ptrs[0]), 144'(0));
        check_eq("basic_nbeats", 144'(beats.size()), 144'(BW));
        for (int k = 0; k < BW; k++) begin
            check_eq($sformatf("basic_w%0d", k), beats[k],
                     {8'h00, 64'(2 * k), 8'h00, 64'(2 * k + 1)});
        end
        check_eq("basic_used_at_store", 144'(used_log[0]), 144'(1));
        check_eq("basic_used", 144'(bus.blocks_used), 144'(1));
        check_eq("basic_gaps", 144'(gaps), 144'(0));

        // Stall: dram_wr_full high on transfer cycles 3-5.
        clear_logs();
        stall_en = 1;
        push_block(64'd100, 1'b1);
        wait_stored(1, "stall_done");
        stall_en = 0;
        check_eq("stall_ptr", 144'(ptrs[0]), 144'(16));
        check_eq("stall_nbeats", 144'(beats.size()), 144'(BW));
        check_eq("stall_gaps", 144'(gaps), 144'(3));
        for (int k = 0; k < BW; k++) begin
            check_eq($sformatf("stall_w%0d", k), beats[k],
                     {8'(2 * k + 1), 64'(100 + 2 * k), 8'(2 * k + 2), 64'(101 + 2 * k)});
        end
        check_eq("stall_used", 144'(bus.blocks_used), 144'(2));

        // Third block reaches 3, then done and rd_blk_done coincide.
        clear_logs();
        push_block(64'd200, 1'b0);
        wait_stored(1, "third_done");
        check_eq("third_ptr", 144'(ptrs[0]), 144'(32));
        check_eq("third_used", 144'(used_log[0]), 144'(3));
        clear_logs();
        rd_with_done = 1;
        push_block(64'd300, 1'b0);
        wait_stored(1, "simul_done");
        rd_with_done = 0;
        check_eq("simul_ptr", 144'(ptrs[0]), 144'(48));
        check_eq("simul_used_at_store", 144'(used_log[0]), 144'(3));
        check_eq("simul_used", 144'(bus.blocks_used), 144'(3));

        // Reset in the middle of a transfer.
        clear_logs();
        push_block(64'd400, 1'b0);
        begin
            int n = 0;
            while (beats.size() < 3 && n < 500) begin
                @(posedge clk);
                n++;
            end
            check_eq("mid_beats_seen", 144'(beats.size() >= 3), 144'(1));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("mid_vld", 144'(bus.dram_wr_data_vld), 144'(0));
        check_eq("mid_req", 144'(bus.dram_wr_req), 144'(0));
        check_eq("mid_data", bus.dram_wr_data, 144'(0));
        check_eq("mid_used", 144'(bus.blocks_used), 144'(0));
        check_eq("mid_ptr", 144'(bus.dram_wr_ptr), 144'(0));
        check_eq("mid_in_rdy", 144'(bus.in_rdy), 144'(1));
        repeat (2) @(negedge clk);
        clear_logs();
        reset = 1'b0;
        @(negedge clk);

        // Three words then idle.
        for (int i = 0; i < 3; i++) begin
            push_word(64'hA0 + 64'(i), 8'h10 + 8'(i));
        end
`ifdef DRAM_WR_FLUSH_EN
        wait_stored(1, "flush_done");
        check_eq("flush_ptr", 144'(ptrs[0]), 144'(0));
        check_eq("flush_nbeats", 144'(beats.size()), 144'(BW));
        check_eq("flush_w0", beats[0], {8'h10, 64'hA0, 8'h11, 64'hA1});
        check_eq("flush_w1", beats[1], {8'h12, 64'hA2, 72'h0});
        for (int k = 2; k < BW; k++) begin
            check_eq($sformatf("flush_w%0d", k), beats[k], 144'(0));
        end
        check_eq("flush_used", 144'(bus.blocks_used), 144'(1));
`else
        repeat (60) @(negedge clk);
        check_eq("noflush_nreq", 144'(ptrs.size()), 144'(0));
        check_eq("noflush_req", 144'(bus.dram_wr_req), 144'(0));
`endif
        do_reset();

        // Fill the whole region without reads.
        for (int b = 0; b < 64; b++) begin
            push_block(64'(b * 32), 1'b0);
        end
        wait_stored(64, "full_done");
        check_eq("full_nreq", 144'(ptrs.size()), 144'(64));
        check_eq("full_ptr1", 144'(ptrs[1]), 144'(16));
        check_eq("full_ptr2", 144'(ptrs[2]), 144'(32));
        check_eq("full_ptr3", 144'(ptrs[3]), 144'(48));
        check_eq("full_ptr63", 144'(ptrs[63]), 144'(1008));
        check_eq("full_used_log", 144'(used_log[63]), 144'(64));
        check_eq("full_used", 144'(bus.blocks_used), 144'(64));
        check_eq("full_qfull", 144'(bus.dram_q_full), 144'(1));
        for (int i = 0; i < 64; i++) begin
            push_word(64'h5000 + 64'(i), 8'h00);
        end
        check_eq("full_in_rdy", 144'(bus.in_rdy), 144'(0));
        repeat (20) @(negedge clk);
        check_eq("full_no_req", 144'(bus.dram_wr_req), 144'(0));
        check_eq("full_nreq_held", 144'(ptrs.size()), 144'(64));
        rd_once = 1;
        begin
            int n = 0;
            while (ptrs.size() < 65 && n < 200) begin
                @(posedge clk);
                n++;
            end
            check_eq("wrap_req_seen", 144'(ptrs.size() >= 65), 144'(1));
        end
        @(negedge clk);
        check_eq("wrap_ptr", 144'(ptrs[64]), 144'(0));
        check_eq("wrap_used_after_rd", 144'(bus.blocks_used), 144'(63));
        wait_stored(65, "wrap_done");
        check_eq("wrap_used_log", 144'(used_log[64]), 144'(64));
        check_eq("wrap_qfull", 144'(bus.dram_q_full), 144'(1));
        check_eq("wrap_in_rdy", 144'(bus.in_rdy), 144'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
